// File: rtl/reg_write_queue.sv
// Write-request FIFO feeding the register bank's w/select_register/s inputs, one strobe per clock in order.
// Optional WB_BYPASS_EN: an accept into an empty, un-held queue goes straight to the bank outputs.
module reg_write_queue #(
    parameter int unsigned N          = 16,
    parameter int unsigned AW         = 4,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [N-1:0]  req_data,
    input  logic          hold,
    output logic          w,
    output logic [AW-1:0] select_register,
    output logic [N-1:0]  s,
    output logic          busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } entry_t;

    entry_t                mem [DEPTH];
    entry_t                head;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [CW-1:0]         count;
    logic                  accept;
    logic                  issue;
    logic                  bypass;
    logic                  push;

    assign req_ready = (count < CW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign issue     = !hold && (count != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || w;

`ifdef WB_BYPASS_EN
    assign bypass = accept && (count == '0) && !hold;
`else
    assign bypass = 1'b0;
`endif

    // Bypassed requests never touch the FIFO storage or pointers.
    assign push = accept && !bypass;

    // Entry storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'{addr: req_addr, data: req_data};
        end
    end

    // Pointers, occupancy and the registered bank write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            w               <= 1'b0;
            select_register <= '0;
            s               <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            w <= issue || bypass;
            if (issue) begin
                select_register <= head.addr;
                s               <= head.data;
            end else if (bypass) begin
                select_register <= req_addr;
                s               <= req_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_queue.sv
// Directed bench for reg_write_queue: scoreboard of accepted requests checked against each write strobe.
module tb_reg_write_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr;
    logic [15:0] req_data;
    logic        hold;
    logic        w;
    logic [3:0]  select_register;
    logic [15:0] s;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          wcnt = 0;
    int          streak = 0;
    int          max_streak = 0;
    logic [19:0] sb[$];

    reg_write_queue #(.N(16), .AW(4), .DEPTH_LOG2(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .hold(hold), .w(w),
        .select_register(select_register), .s(s), .busy(busy)
    );

    always #5 clk = ~clk;

    // Every strobe must match the oldest accepted request.
    always @(negedge clk) begin
        if (w === 1'b1) begin
            logic [19:0] exp;
            wcnt++;
            streak++;
            if (streak > max_streak) max_streak = streak;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL spurious_w got addr=%h data=%h exp no strobe", select_register, s);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                checks++;
                assert ({select_register, s} === exp) else begin
                    errors++;
                    $error("FAIL wdata got %h exp %h", {select_register, s}, exp);
                end
            end
        end else begin
            streak = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Present a request (left valid afterwards) and record it once accepted.
    task automatic send(input logic [3:0] a, input logic [15:0] d);
        int t = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("send_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        sb.push_back({a, d});
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("drain_sb", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int w0;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; hold = 1'b0;

        // 1: reset with random inputs
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'($urandom); req_addr = 4'($urandom);
            req_data = 16'($urandom); hold = 1'($urandom);
            @(negedge clk);
            chk("rst_w", 32'(w), 32'd0);
            chk("rst_sel_s", {12'd0, select_register, s}, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        req_valid = 1'b0; hold = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // 2: single request latency
        @(posedge clk); #1;
        send(4'h9, 16'h0404);
        req_valid = 1'b0;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("lat_k", 32'(w), 32'd1);
        @(negedge clk);
        chk("lat_k1", 32'(w), 32'd0);
`else
        chk("lat_k", 32'(w), 32'd0);
        @(negedge clk);
        chk("lat_k1", 32'(w), 32'd1);
        chk("lat_sel_s", {12'd0, select_register, s}, 32'h0009_0404);
        @(negedge clk);
        chk("lat_k2", 32'(w), 32'd0);
`endif
        drain();

        // 3: hold fills queue, 5th stalls, release gives in-order run
        @(posedge clk); #1;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) send(4'(i), 16'h0010 + 16'(i));
        req_valid = 1'b1; req_addr = 4'h4; req_data = 16'h0014;
        @(negedge clk);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("hold_no_w", 32'(w), 32'd0);
        @(posedge clk); #1;
        max_streak = 0;
        hold = 1'b0;
        send(4'h4, 16'h0014);
        req_valid = 1'b0;
        drain();
        chk("hold_streak", 32'(max_streak), 32'd5);

        // 4: ten back-to-back requests through the wrapping FIFO
        @(posedge clk); #1;
        max_streak = 0;
        w0 = wcnt;
        for (int i = 0; i < 10; i++) send(4'(i), 16'hA000 + 16'(i * 3));
        req_valid = 1'b0;
        drain();
        chk("b2b_count", 32'(wcnt - w0), 32'd10);
        chk("b2b_streak", 32'(max_streak), 32'd10);

        // 5: reset discards pending entries and kills an active strobe
        @(posedge clk); #1;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) send(4'hC + 4'(i), 16'hBEE0 + 16'(i));
        req_valid = 1'b0;
        hold = 1'b0;
        @(posedge clk); #1;
        hold = 1'b1;
        @(negedge clk);
        #2;
        chk("pre_rst_w", 32'(w), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_w", 32'(w), 32'd0);
        chk("mid_rst_sel_s", {12'd0, select_register, s}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1; hold = 1'b0;
        w0 = wcnt;
        repeat (10) @(negedge clk);
        chk("no_ghost_w", 32'(wcnt - w0), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // 6: full queue drains while new requests wait for space
        @(posedge clk); #1;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) send(4'hF - 4'(i), 16'h5500 + 16'(i));
        req_valid = 1'b1; req_addr = 4'h7; req_data = 16'h7777;
        @(posedge clk); #1;
        hold = 1'b0;
        @(negedge clk);
        chk("full_issue_ready", 32'(req_ready), 32'd0);
        w0 = wcnt;
        send(4'h7, 16'h7777);
        send(4'h6, 16'h6666);
        send(4'h5, 16'h5555);
        req_valid = 1'b0;
        drain();
        chk("full_total", 32'(wcnt - w0), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_write_queue.md
Name: reg_write_queue

Overview:
Write-request buffer that sits directly upstream of the 16-entry register bank and drives its w / select_register / s inputs. Producers (ALU writeback, loader) push address+data requests through a valid/ready handshake. The queue stores them in a small FIFO and issues at most one registered write strobe per clock, in arrival order. A hold input lets the consumer freeze writes while the bank is being sampled.

Parameters:
N, 16, data width; must match the register bank width.
AW, 4, register address width (16 registers).
DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4); minimum 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
req_valid  input  1  producer has a write request
req_ready  output  1  queue can accept a request this cycle
req_addr  input  AW  target register index (0 = first register)
req_data  input  N  data to write
hold  input  1  1 = suppress issuing writes
w  output  1  write strobe to register bank (registered)
select_register  output  AW  write address to register bank (registered)
s  output  N  write data to register bank (registered)
busy  output  1  entries pending or write strobe active

Behaviour:
- Clock and reset: one clock `clk`. Asynchronous active-low reset `rst`.
- Reset (rst=0, takes effect immediately, independent of clk):
  - count=0, rd_ptr=0, wr_ptr=0.
  - w=0, select_register=0, s=0.
  - All pending entries are discarded.
  - req_ready=1 and busy=0 once rst=1.
- Accept:
  - req_ready = (count < DEPTH), combinational from count only.
  - On an edge with req_valid && req_ready, {req_addr, req_data} is written at wr_ptr and wr_ptr increments.
  - A request while full is not accepted; the producer must hold it stable until req_ready is 1.
- Issue:
  - On each edge with hold=0 and count>0 (pre-edge value), the head entry loads into select_register/s, w<=1, and rd_ptr increments.
  - Otherwise w<=0, and select_register/s keep their previous values.
  - w is high for exactly one cycle per entry.
  - Back-to-back entries give consecutive w=1 cycles (throughput 1 write/clk).
- Latency: a request accepted at edge k into an empty queue, with hold=0, gives w=1 in the cycle after edge k+1. The bank captures it at edge k+2.
- Simultaneous accept and issue: both occur on the same edge and count is unchanged.
  - Full queue: issue proceeds, but req_ready is still 0 that cycle; no same-cycle refill.
  - Empty queue: an incoming request cannot be issued on its accept edge (except with the optional feature).
- Wrap-around: pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. count is DEPTH_LOG2+1 bits and ranges 0..DEPTH.
- hold:
  - hold=1 freezes rd_ptr, and w goes 0 at the next edge.
  - Accepts continue until the queue is full.
  - Deasserting hold resumes issue in order, with no loss or duplication.
- Ordering: strict FIFO. Writes to the same address are not coalesced, so the later data wins in the bank.
- busy = (count != 0) || w.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: when count==0, hold=0 and a request is accepted, it is loaded directly into select_register/s with w<=1 on that same edge. The FIFO is not written and its pointers do not move. Latency drops to 1 edge; all other rules are unchanged.
- Undefined: there is no bypass, and every request passes through the FIFO with the latency stated above.

Test Plan:
1. Hold rst=0 with random inputs -> w=0, select_register=0, s=0, busy=0; after rst=1, req_ready=1.
2. Single request addr=4'h9, data=16'h0404, hold=0, accepted at edge k -> w=1 for exactly one cycle after edge k+1 (after edge k with WB_BYPASS_EN), select_register=9, s=16'h0404.
3. hold=1, issue 5 requests (addr 0..4, data 16'h0010+i) -> first 4 accepted, req_ready=0 while the 5th is presented.
   - Release hold -> 4 consecutive w pulses for addr 0,1,2,3, then the 5th is accepted and issued.
4. 10 back-to-back requests (addr 0..9), hold=0, req_valid held high -> 10 consecutive w pulses in order with the correct data, demonstrating pointer wrap and count never exceeding 4.
5. 3 entries pending with hold=1, then pulse rst=0 mid-cycle -> w=0 immediately; after release and hold=0, no write strobe ever appears for the discarded entries and busy=0.
6. Full queue with hold=0, new request valid -> one issue per cycle; req_ready rises only after count drops below 4, and no request is dropped or duplicated.
